// File: rtl/dp_affine_sched.sv
// Loop-nest consumer scheduler: walks an NLOOP-deep index space, forms one affine
// read address per operand stream, and paces NSTREAM producers with prefetch windows.
module dp_affine_sched #(
  parameter int NLOOP   = 6,
  parameter int NSTREAM = 2,
  parameter int IDXW    = 8,
  parameter int AW      = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NLOOP*IDXW-1:0]       i_size,
  input  logic [NSTREAM*NLOOP*AW-1:0] i_stride,
  input  logic [NSTREAM*(AW+1)-1:0]   i_total,
  input  logic [NSTREAM*AW-1:0]       i_win,
  input  logic                        i_inst_dval,
  input  logic                        i_start,
  input  logic                        i_stall,
  input  logic                        i_abort,
  input  logic                        i_next,
  input  logic [NSTREAM-1:0]          i_prod_rdy,
  output logic [NSTREAM-1:0]          o_prod_ack,
  output logic                        o_main_rdy,
  input  logic                        i_main_ack,
  output logic [NSTREAM-1:0]          o_wen,
  output logic [NSTREAM*AW-1:0]       o_waddr,
  output logic                        o_ren,
  output logic [NSTREAM*AW-1:0]       o_raddr,
  output logic [NLOOP*IDXW-1:0]       o_loop_idx,
  output logic [NLOOP-1:0]            o_loop_end,
  output logic [1:0]                  o_state,
  output logic                        o_conf_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, WORK = 2'd2, STALL = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] size_q [NLOOP];
  logic [IDXW-1:0] idx_q  [NLOOP];
  logic [IDXW-1:0] idx_d  [NLOOP];
  logic [AW-1:0]   stride_q [NSTREAM][NLOOP];
  logic [AW-1:0]   base_q   [NSTREAM][NLOOP];
  logic [AW-1:0]   base_d   [NSTREAM][NLOOP];
  logic [AW:0]     total_q [NSTREAM];
  logic [AW-1:0]   win_q   [NSTREAM];
  logic [AW:0]     cnt_q   [NSTREAM];
  logic [AW:0]     cnt_d   [NSTREAM];
  logic            conf_done_q, done_d, abort_clr;
  logic [NLOOP-1:0] loop_end;
  logic [NLOOP:0]   carry;
  logic             in_work, beat, last_beat;

  function automatic logic [IDXW-1:0] min1_idx(input logic [IDXW-1:0] v);
    return (v == '0) ? IDXW'(1) : v;
  endfunction

  function automatic logic [AW-1:0] min1_addr(input logic [AW-1:0] v);
    return (v == '0) ? AW'(1) : v;
  endfunction

  function automatic logic [AW:0] sat_inc(input logic [AW:0] v, input logic [AW:0] lim);
    if (v >= lim) return lim;
    return v + (AW+1)'(1);
  endfunction

  assign in_work = (state_q == WORK);

  // Handshake terms depend only on registered state; strobes fold in the peer's side.
  always_comb begin
    for (int l = 0; l < NLOOP; l++)
      loop_end[l] = (idx_q[l] == size_q[l] - IDXW'(1));
    o_main_rdy = in_work;
    for (int s = 0; s < NSTREAM; s++) begin
      o_main_rdy    = o_main_rdy & (cnt_q[s] > {1'b0, base_q[s][0]});
      o_prod_ack[s] = in_work && (cnt_q[s] < total_q[s]) &&
                      (cnt_q[s] < ({1'b0, base_q[s][0]} + {1'b0, win_q[s]}));
    end
  end

  assign o_wen     = i_prod_rdy & o_prod_ack;
  assign o_ren     = o_main_rdy & i_main_ack;
  assign beat      = o_ren;
  assign last_beat = carry[NLOOP];

  // Base register l holds the address with every level below l at zero, so the
  // lowest non-wrapping level k supplies base[k]+stride[k] to all levels <= k.
  always_comb begin
    logic [AW-1:0] nb;
    carry    = '0;
    carry[0] = beat;
    for (int l = 0; l < NLOOP; l++)
      carry[l+1] = carry[l] & loop_end[l];
    for (int l = 0; l < NLOOP; l++)
      idx_d[l] = carry[l] ? (loop_end[l] ? '0 : idx_q[l] + IDXW'(1)) : idx_q[l];
    for (int s = 0; s < NSTREAM; s++) begin
      nb = '0;
      for (int l = NLOOP - 1; l >= 0; l--) begin
        base_d[s][l] = base_q[s][l];
        if (carry[l] && !loop_end[l]) nb = base_q[s][l] + stride_q[s][l];
        if (carry[l]) base_d[s][l] = nb;
      end
      cnt_d[s] = o_wen[s] ? sat_inc(cnt_q[s], total_q[s]) : cnt_q[s];
    end
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    abort_clr = 1'b0;
    unique case (state_q)
      IDLE: if (i_inst_dval && i_start) state_d = INIT;
      INIT: if (i_inst_dval) begin
        if (i_abort) begin
          state_d   = IDLE;
          abort_clr = 1'b1;
        end else begin
          state_d = WORK;
        end
      end
      WORK: begin
        if (i_inst_dval && i_abort) begin
          state_d   = IDLE;
          abort_clr = 1'b1;
        end else if (i_inst_dval && i_next) begin
          state_d = INIT;
        end else if (last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (i_inst_dval && i_stall) begin
          state_d = STALL;
        end
      end
      STALL: if (i_inst_dval) begin
        if (i_abort) begin
          state_d   = IDLE;
          abort_clr = 1'b1;
        end else if (!i_stall) begin
          state_d = WORK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      conf_done_q <= 1'b0;
      for (int l = 0; l < NLOOP; l++) begin
        idx_q[l]  <= '0;
        size_q[l] <= IDXW'(1);
      end
      for (int s = 0; s < NSTREAM; s++) begin
        cnt_q[s] <= '0;
        for (int l = 0; l < NLOOP; l++) base_q[s][l] <= '0;
      end
    end else begin
      state_q     <= state_d;
      conf_done_q <= done_d;
      if (state_q == INIT)
        for (int l = 0; l < NLOOP; l++) size_q[l] <= min1_idx(i_size[l*IDXW +: IDXW]);
      for (int l = 0; l < NLOOP; l++)
        idx_q[l] <= (state_q == INIT || abort_clr) ? '0 : idx_d[l];
      for (int s = 0; s < NSTREAM; s++) begin
        cnt_q[s] <= (state_q == INIT || abort_clr) ? '0 : cnt_d[s];
        for (int l = 0; l < NLOOP; l++)
          base_q[s][l] <= (state_q == INIT || abort_clr) ? '0 : base_d[s][l];
      end
    end
  end

  // Per-stream configuration is plain data: captured in INIT, never reset.
  always_ff @(posedge i_clk) begin
    if (state_q == INIT) begin
      for (int s = 0; s < NSTREAM; s++) begin
        total_q[s] <= i_total[s*(AW+1) +: AW+1];
        win_q[s]   <= min1_addr(i_win[s*AW +: AW]);
        for (int l = 0; l < NLOOP; l++)
          stride_q[s][l] <= i_stride[(s*NLOOP+l)*AW +: AW];
      end
    end
  end

  for (genvar s = 0; s < NSTREAM; s++) begin : g_strm
    assign o_waddr[s*AW +: AW] = cnt_q[s][AW-1:0];
    assign o_raddr[s*AW +: AW] = base_q[s][0];
  end

  for (genvar l = 0; l < NLOOP; l++) begin : g_lvl
    assign o_loop_idx[l*IDXW +: IDXW] = idx_q[l];
  end

  assign o_loop_end  = loop_end;
  assign o_state     = state_q;
  assign o_conf_done = conf_done_q;

endmodule
